bus_interconnect: RTL and testbench
===================================

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
- REQ-001: Parameter N_MASTERS, default 2, number of bus masters (range 1..4).
- REQ-002: Parameter N_SLAVES, default 2, number of bus slaves (range 1..4).
- REQ-003: Parameter SLAVE_BASE[N_SLAVES], default {0x0, 0x100}, base word address per slave.
- REQ-004: Parameter SLAVE_SIZE[N_SLAVES], default {2**RAM_WIDTH, 4}, window size in words per slave.
- REQ-005: Parameter TIMEOUT_CYCLES, default 16, number of ACCESS cycles before a timeout error.
- REQ-006: clk  in  1  single clock; all logic is rising-edge.
- REQ-007: rst  in  1  asynchronous, active-low reset.
- REQ-008: m_req  in  N_MASTERS  per-master request.
- REQ-009: m_addr  in  N_MASTERS x 30  word address.
- REQ-010: m_we / m_mem_read  in  N_MASTERS each  write / read strobe.
- REQ-011: m_mask_byte  in  N_MASTERS x 4, and m_wdata  in  N_MASTERS x 32.
- REQ-012: m_gnt  out  N_MASTERS  one-cycle pulse marking command capture.
- REQ-013: m_rsp_valid  out  N_MASTERS; m_rdata  out  32 (shared); m_err  out  1 (shared).
- REQ-014: s_sel  out  N_SLAVES; s_addr  out  30; s_we, s_mem_read  out  1 each; s_mask_byte  out  4; s_wdata  out  32.
- REQ-015: s_rdata  in  N_SLAVES x 32; s_rsp_valid  in  N_SLAVES.
- REQ-016: busy  out  1  high whenever the state is not IDLE.

Function
- REQ-017: The FSM SHALL have the states IDLE, ACCESS, RESP and ERR.
- REQ-018: In IDLE with any m_req set, the block SHALL grant round-robin starting from last_grant+1, pulse m_gnt[i] in the same cycle, and register the command.
- REQ-019: Decode on capture: slave k hits when SLAVE_BASE[k] <= addr < SLAVE_BASE[k]+SLAVE_SIZE[k]; the lowest k wins on overlap; a hit SHALL go to ACCESS, no hit SHALL go to ERR.
- REQ-020: In ACCESS, s_sel[k] and the registered command SHALL be held stable until s_rsp_valid[k]; s_rdata[k] is then captured and the FSM goes to RESP.
- REQ-021: In RESP, m_rsp_valid[i]=1 for exactly one cycle with m_rdata set to the captured data and m_err=0; the FSM then returns to IDLE.
- REQ-022: In ERR, m_rsp_valid[i]=1 for one cycle with m_err=1 and m_rdata=0; the FSM then returns to IDLE.
- REQ-023: Minimum latency is grant at cycle 0, s_sel at cycle 1, m_rsp_valid at cycle 2, for a slave that responds in its select cycle.
- REQ-024: s_rsp_valid from an unselected slave SHALL be ignored.
- REQ-025: m_req is not sampled outside IDLE; a request dropped before its grant is lost.
- REQ-026: last_grant SHALL update on each grant; there is no back-to-back grant bubble beyond RESP/ERR.
- REQ-027: When idle, all s_* outputs SHALL be 0, except that s_addr/s_wdata may hold their last values.

Reset
- REQ-028: rst low SHALL force IDLE asynchronously, including mid-ACCESS.
- REQ-029: During reset, s_sel, m_gnt, m_rsp_valid, m_err, busy, m_rdata and the timeout counter SHALL be 0.
- REQ-030: Reset SHALL set last_grant=N_MASTERS-1, so master 0 wins the first arbitration.

Configuration
- REQ-031: With BUS_TIMEOUT_EN defined, a counter SHALL run in ACCESS; after TIMEOUT_CYCLES cycles without s_rsp_valid, s_sel drops and the FSM goes to ERR.
- REQ-032: Without BUS_TIMEOUT_EN, the counter is absent and ACCESS waits indefinitely.

Structure
- REQ-033: Package bus_pkg SHALL hold the bus_cmd_t struct (addr, we, mem_read, mask_byte, wdata), the state enum, and the MAX_MASTERS/MAX_SLAVES=4 constants.
- REQ-034: Sub-module rr_arbiter SHALL implement the parametrised round-robin grant (inputs req and last_grant, output one-hot grant).

Verification
- REQ-035: Master 0 reads addr 0x10 with slave 0 responding the same cycle with 0xDEADBEEF -> m_gnt[0] at cycle 0, m_rsp_valid[0]=1 at cycle 2 with m_rdata=0xDEADBEEF.
- REQ-036: Both masters request continuously -> grants alternate 0,1,0,1, with no master granted twice in a row.
- REQ-037: Master 1 writes 0x41 to addr 0x100 -> s_sel[1]=1, s_we=1, s_wdata=0x41; m_rsp_valid[1] follows with m_err=0.
- REQ-038: Access to addr 0x3FFFFFFF -> no s_sel asserted; m_rsp_valid=1 with m_err=1 and m_rdata=0 two cycles after grant.
- REQ-039: With BUS_TIMEOUT_EN and a slave that never responds -> s_sel drops after 16 cycles, then m_err=1; without the macro, busy stays high.
- REQ-040: rst pulsed low mid-ACCESS -> s_sel=0 and busy=0 immediately; next simultaneous requests grant master 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus interconnect: command struct, FSM states and
// master/slave count limits.
package bus_pkg;

  localparam int unsigned MAX_MASTERS = 4;
  localparam int unsigned MAX_SLAVES  = 4;
  localparam int unsigned IDX_W       = $clog2(MAX_MASTERS);

  typedef struct packed {
    logic [29:0] addr;
    logic        we;
    logic        mem_read;
    logic [3:0]  mask_byte;
    logic [31:0] wdata;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp,
    StErr
  } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant_i, wrapping
// around through all N requesters.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int off = 1; off <= int'(N); off++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!found && req_i[i] && (i == (int'(last_grant_i) + off) % int'(N))) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Multi-master / multi-slave bus interconnect with round-robin arbitration and address decode.
// Optional ACCESS timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned N_SLAVES  = 2,
  parameter int unsigned RAM_WIDTH = 8,
  parameter logic [N_SLAVES-1:0][31:0] SLAVE_BASE = {32'h100, 32'h0},
  parameter logic [N_SLAVES-1:0][31:0] SLAVE_SIZE = {32'd4, 32'(2 ** RAM_WIDTH)},
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_MASTERS-1:0]    m_req_i,
  input  logic [N_MASTERS*30-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS-1:0]    m_mem_read_i,
  input  logic [N_MASTERS*4-1:0]  m_mask_byte_i,
  input  logic [N_MASTERS*32-1:0] m_wdata_i,
  output logic [N_MASTERS-1:0]    m_gnt_o,
  output logic [N_MASTERS-1:0]    m_rsp_valid_o,
  output logic [31:0]             m_rdata_o,
  output logic                    m_err_o,
  output logic [N_SLAVES-1:0]     s_sel_o,
  output logic [29:0]             s_addr_o,
  output logic                    s_we_o,
  output logic                    s_mem_read_o,
  output logic [3:0]              s_mask_byte_o,
  output logic [31:0]             s_wdata_o,
  input  logic [N_SLAVES*32-1:0]  s_rdata_i,
  input  logic [N_SLAVES-1:0]     s_rsp_valid_i,
  output logic                    busy_o
);

  bus_state_e       state_q, state_d;
  bus_cmd_t         cmd_q, cmd_d, sel_cmd;
  logic [IDX_W-1:0] owner_q, owner_d, slave_q, slave_d, last_q, last_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_wait_q, err_wait_d;
  logic [N_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0] gnt_idx, hit_idx;
  logic             hit, rsp_hit, err_rsp;
  logic [31:0]      rsp_data;
  logic [32:0]      addr_ext, base_ext, lim_ext;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter #(
    .N(N_MASTERS)
  ) u_arb (
    .req_i       (m_req_i),
    .last_grant_i(last_q),
    .grant_o     (arb_grant)
  );

  // Winning master's command and the slave it decodes to.
  always_comb begin
    gnt_idx = '0;
    sel_cmd = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (arb_grant[i]) begin
        gnt_idx = IDX_W'(i);
        sel_cmd = '{addr: m_addr_i[i*30 +: 30], we: m_we_i[i], mem_read: m_mem_read_i[i],
                    mask_byte: m_mask_byte_i[i*4 +: 4], wdata: m_wdata_i[i*32 +: 32]};
      end
    end
    hit      = 1'b0;
    hit_idx  = '0;
    addr_ext = {3'b000, sel_cmd.addr};
    base_ext = '0;
    lim_ext  = '0;
    // Descending scan so the lowest matching slave wins on overlap.
    for (int k = int'(N_SLAVES) - 1; k >= 0; k--) begin
      base_ext = {1'b0, SLAVE_BASE[k]};
      lim_ext  = base_ext + {1'b0, SLAVE_SIZE[k]};
      if (addr_ext >= base_ext && addr_ext < lim_ext) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Only the selected slave's response is observed.
  always_comb begin
    rsp_hit  = 1'b0;
    rsp_data = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      if (slave_q == IDX_W'(k)) begin
        rsp_hit  = s_rsp_valid_i[k];
        rsp_data = s_rdata_i[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    owner_d    = owner_q;
    slave_d    = slave_q;
    last_d     = last_q;
    rdata_d    = rdata_q;
    err_wait_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|m_req_i) begin
          cmd_d   = sel_cmd;
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          if (hit) begin
            slave_d = hit_idx;
            state_d = StAccess;
          end else begin
            // Decode misses spend one silent cycle so errors land at the same latency as hits.
            state_d    = StErr;
            err_wait_d = 1'b1;
          end
        end
      end
      StAccess: begin
        if (rsp_hit) begin
          rdata_d = rsp_data;
          state_d = StResp;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp:  state_d = StIdle;
      StErr:   if (!err_wait_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      owner_q    <= '0;
      slave_q    <= '0;
      last_q     <= IDX_W'(N_MASTERS - 1);
      rdata_q    <= '0;
      err_wait_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      owner_q    <= owner_d;
      slave_q    <= slave_d;
      last_q     <= last_d;
      rdata_q    <= rdata_d;
      err_wait_q <= err_wait_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    err_rsp   = (state_q == StErr) && !err_wait_q;
    m_gnt_o   = (state_q == StIdle && rst_ni) ? arb_grant : '0;
    m_rdata_o = (state_q == StResp) ? rdata_q : '0;
    m_err_o   = err_rsp;
    busy_o    = (state_q != StIdle);
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      m_rsp_valid_o[i] = ((state_q == StResp) || err_rsp) && (owner_q == IDX_W'(i));
    end
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      s_sel_o[k] = (state_q == StAccess) && (slave_q == IDX_W'(k));
    end
    s_addr_o      = cmd_q.addr;
    s_wdata_o     = cmd_q.wdata;
    s_we_o        = (state_q == StAccess) && cmd_q.we;
    s_mem_read_o  = (state_q == StAccess) && cmd_q.mem_read;
    s_mask_byte_o = (state_q == StAccess) ? cmd_q.mask_byte : 4'h0;
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed self-checking bench for bus_interconnect (default 2 masters, 2 slaves).
// Covers the BUS_TIMEOUT_EN build when that macro is defined.
module tb_bus_interconnect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  m_req = '0, m_we = '0, m_rd = '0;
  logic [59:0] m_addr = '0;
  logic [7:0]  m_mask = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  m_gnt, m_rsp_valid, s_sel, s_rsp_valid, man_rsp = '0;
  logic [31:0] m_rdata, s_wdata;
  logic [63:0] s_rdata = '0;
  logic [29:0] s_addr;
  logic [3:0]  s_mask;
  logic        m_err, s_we, s_rd, busy, auto_rsp = 1'b1;
  int total = 0;
  int bad = 0;

  assign s_rsp_valid = auto_rsp ? s_sel : man_rsp;

  always #5 clk = ~clk;

  bus_interconnect dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_mem_read_i(m_rd), .m_mask_byte_i(m_mask), .m_wdata_i(m_wdata), .m_gnt_o(m_gnt),
    .m_rsp_valid_o(m_rsp_valid), .m_rdata_o(m_rdata), .m_err_o(m_err), .s_sel_o(s_sel),
    .s_addr_o(s_addr), .s_we_o(s_we), .s_mem_read_o(s_rd), .s_mask_byte_o(s_mask),
    .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_rsp_valid_i(s_rsp_valid), .busy_o(busy)
  );

  task automatic set_master(input int i, input logic [29:0] a, input logic we,
                            input logic [31:0] wd);
    m_addr[i*30 +: 30]  = a;
    m_we[i]             = we;
    m_rd[i]             = !we;
    m_mask[i*4 +: 4]    = 4'hF;
    m_wdata[i*32 +: 32] = wd;
  endtask

  // Drive a request at a negedge and leave time #1 for combinational outputs (cycle 0).
  task automatic issue(input logic [1:0] req);
    @(negedge clk);
    m_req = req;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    m_req = '0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_req = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({s_sel, m_gnt, m_rsp_valid, m_err, busy} !== 8'h00 || m_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: sel=%b gnt=%b rsp=%b err=%b busy=%b rdata=%h, want all 0",
               s_sel, m_gnt, m_rsp_valid, m_err, busy, m_rdata);
    end
    m_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    set_master(0, 30'h10, 1'b0, 32'h0);
    s_rdata[31:0] = 32'hDEADBEEF;
    issue(2'b01);
    total++;
    if (m_gnt !== 2'b01) begin bad++; $display("FAIL read_gnt: got %b want 01", m_gnt); end
    next_cycle();
    total++;
    if (s_sel !== 2'b01 || s_rd !== 1'b1 || s_addr !== 30'h10 || m_rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL read_sel: sel=%b rd=%b addr=%h rsp=%b want 01 1 10 00",
               s_sel, s_rd, s_addr, m_rsp_valid);
    end
    next_cycle();
    total++;
    if (m_rsp_valid !== 2'b01 || m_rdata !== 32'hDEADBEEF || m_err !== 1'b0) begin
      bad++;
      $display("FAIL read_rsp: rsp=%b rdata=%h err=%b want 01 deadbeef 0",
               m_rsp_valid, m_rdata, m_err);
    end
    next_cycle();
    total++;
    if (busy !== 1'b0 || m_rsp_valid !== 2'b00 || s_sel !== 2'b00 || s_rd !== 1'b0) begin
      bad++;
      $display("FAIL read_idle: busy=%b rsp=%b sel=%b rd=%b want 0 00 00 0",
               busy, m_rsp_valid, s_sel, s_rd);
    end
  endtask

  task automatic test_write();
    set_master(1, 30'h100, 1'b1, 32'h41);
    issue(2'b10);
    total++;
    if (m_gnt !== 2'b10) begin bad++; $display("FAIL write_gnt: got %b want 10", m_gnt); end
    next_cycle();
    total++;
    if (s_sel !== 2'b10 || s_we !== 1'b1 || s_wdata !== 32'h41 || s_mask !== 4'hF) begin
      bad++;
      $display("FAIL write_sel: sel=%b we=%b wdata=%h mask=%h want 10 1 41 f",
               s_sel, s_we, s_wdata, s_mask);
    end
    next_cycle();
    total++;
    if (m_rsp_valid !== 2'b10 || m_err !== 1'b0) begin
      bad++;
      $display("FAIL write_rsp: rsp=%b err=%b want 10 0", m_rsp_valid, m_err);
    end
  endtask

  task automatic test_decode_err();
    set_master(0, 30'h3FFFFFFF, 1'b0, 32'h0);
    issue(2'b01);
    next_cycle();
    total++;
    if (s_sel !== 2'b00 || m_rsp_valid !== 2'b00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_c1: sel=%b rsp=%b busy=%b want 00 00 1", s_sel, m_rsp_valid, busy);
    end
    next_cycle();
    total++;
    if (m_rsp_valid !== 2'b01 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      bad++;
      $display("FAIL err_rsp: rsp=%b err=%b rdata=%h want 01 1 0", m_rsp_valid, m_err, m_rdata);
    end
    next_cycle();
    total++;
    if (busy !== 1'b0 || m_err !== 1'b0) begin
      bad++;
      $display("FAIL err_idle: busy=%b err=%b want 0 0", busy, m_err);
    end
  endtask

  task automatic test_boundary();
    logic [29:0] addrs [4] = '{30'h0FF, 30'h100, 30'h103, 30'h104};
    logic [1:0]  sels  [4] = '{2'b01, 2'b10, 2'b10, 2'b00};
    for (int t = 0; t < 4; t++) begin
      set_master(0, addrs[t], 1'b0, 32'h0);
      issue(2'b01);
      next_cycle();
      total++;
      if (s_sel !== sels[t]) begin
        bad++;
        $display("FAIL bound_sel[%0d]: addr=%h sel=%b want %b", t, addrs[t], s_sel, sels[t]);
      end
      next_cycle();
      total++;
      if (m_err !== (sels[t] == 2'b00) || m_rsp_valid !== 2'b01) begin
        bad++;
        $display("FAIL bound_rsp[%0d]: err=%b rsp=%b want %b 01", t, m_err, m_rsp_valid,
                 sels[t] == 2'b00);
      end
      next_cycle();
    end
  endtask

  task automatic test_ignore_unselected();
    auto_rsp = 1'b0;
    s_rdata  = {32'h11111111, 32'h22222222};
    set_master(0, 30'h20, 1'b0, 32'h0);
    issue(2'b01);
    @(negedge clk);
    m_req   = '0;
    man_rsp = 2'b10;
    #1;
    next_cycle();
    total++;
    if (m_rsp_valid !== 2'b00 || busy !== 1'b1 || s_sel !== 2'b01) begin
      bad++;
      $display("FAIL unsel_ignored: rsp=%b busy=%b sel=%b want 00 1 01", m_rsp_valid, busy, s_sel);
    end
    man_rsp = 2'b01;
    next_cycle();
    man_rsp = 2'b00;
    total++;
    if (m_rsp_valid !== 2'b01 || m_rdata !== 32'h22222222) begin
      bad++;
      $display("FAIL unsel_rsp: rsp=%b rdata=%h want 01 22222222", m_rsp_valid, m_rdata);
    end
    auto_rsp = 1'b1;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] grants [4];
    int         times  [4];
    int         n = 0;
    test_reset();
    set_master(0, 30'h30, 1'b0, 32'h0);
    set_master(1, 30'h101, 1'b0, 32'h0);
    @(negedge clk);
    m_req = 2'b11;
    for (int c = 0; c < 30 && n < 4; c++) begin
      #1;
      if (m_gnt != 2'b00) begin
        grants[n] = m_gnt;
        times[n]  = c;
        n++;
      end
      @(negedge clk);
    end
    m_req = '0;
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL b2b_count: saw %0d grants want 4", n);
    end else begin
      for (int g = 0; g < 4; g++) begin
        total++;
        if (grants[g] !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++;
          $display("FAIL b2b_order[%0d]: got %b want %b", g, grants[g],
                   (g % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      total++;
      if (times[3] - times[0] != 9) begin
        bad++;
        $display("FAIL b2b_spacing: 4 grants span %0d cycles want 9", times[3] - times[0]);
      end
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_timeout();
    auto_rsp = 1'b0;
    man_rsp  = '0;
    set_master(0, 30'h10, 1'b0, 32'h0);
    issue(2'b01);
    repeat (16) next_cycle();
`ifdef BUS_TIMEOUT_EN
    total++;
    if (s_sel !== 2'b01) begin bad++; $display("FAIL to_sel16: sel=%b want 01", s_sel); end
    next_cycle();
    total++;
    if (s_sel !== 2'b00 || m_err !== 1'b1 || m_rsp_valid !== 2'b01) begin
      bad++;
      $display("FAIL to_err: sel=%b err=%b rsp=%b want 00 1 01", s_sel, m_err, m_rsp_valid);
    end
    // Start another access left hanging for the mid-access reset test.
    next_cycle();
    issue(2'b01);
    next_cycle();
`else
    repeat (24) next_cycle();
    total++;
    if (busy !== 1'b1 || s_sel !== 2'b01) begin
      bad++;
      $display("FAIL to_wait: busy=%b sel=%b want 1 01", busy, s_sel);
    end
`endif
  endtask

  task automatic test_reset_mid_access();
    total++;
    if (s_sel !== 2'b01) begin bad++; $display("FAIL mid_pre: sel=%b want 01", s_sel); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (s_sel !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: sel=%b busy=%b want 00 0", s_sel, busy);
    end
    auto_rsp = 1'b1;
    set_master(1, 30'h100, 1'b0, 32'h0);
    @(negedge clk);
    m_req = 2'b11;
    rst_n = 1'b1;
    #1;
    total++;
    if (m_gnt !== 2'b01) begin bad++; $display("FAIL mid_regrant: gnt=%b want 01", m_gnt); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_err();
    test_boundary();
    test_ignore_unselected();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
